// File: rtl/fir_stream_sequencer.sv
// fir_stream_sequencer: coefficient loader and slow-clock sample streamer for the W4823 FIR.
// Optional sticky fp16 denormal detection is built when FIR_SEQ_DENORM_CHECK_EN is defined.
module fir_stream_sequencer #(
   parameter int unsigned DW            = 16,
   parameter int unsigned OW            = 29,
   parameter int unsigned NTAPS         = 65,
   parameter int unsigned SAMPLE_LEN    = 500,
   parameter int unsigned DIV_LOG2      = 8,
   parameter int unsigned CAPTURE_PHASE = 18,
   parameter int unsigned SKIP_SLOTS    = 16,
   localparam int unsigned CAW =
      (NTAPS > 1) ? $clog2(NTAPS) : 1,
   localparam int unsigned SAW =
      (SAMPLE_LEN > 1) ? $clog2(SAMPLE_LEN) : 1
) (
   input  logic            clk_fast,
   input  logic            rst_n,
   input  logic            start,
   input  logic            abort,
   input  logic [15:0]     run_slots,
   input  logic [DW-1:0]   coef_q,
   input  logic [DW-1:0]   sample_q,
   output logic [SAW-1:0]  sample_addr,
   output logic [CAW-1:0]  fir_caddr,
   output logic [DW-1:0]   fir_cin,
   output logic            fir_cload,
   output logic            fir_clk_slow,
   output logic [DW-1:0]   fir_din,
   input  logic [OW-1:0]   fir_dout,
   output logic [OW-1:0]   out_data,
   output logic            out_valid,
   output logic            busy,
   output logic            done,
   output logic            denorm_flag
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_LOAD,
      S_RUN,
      S_DONE
   } state_e;

   localparam logic [CAW-1:0] CLAST =
      CAW'(NTAPS - 1);
   localparam logic [SAW-1:0] SLAST =
      SAW'(SAMPLE_LEN - 1);
   localparam logic [DIV_LOG2-1:0] DMAX =
      '1;
   localparam logic [DIV_LOG2-1:0] CPHASE =
      DIV_LOG2'(CAPTURE_PHASE);
   localparam logic [15:0] SKIP =
      16'(SKIP_SLOTS);

   state_e              state_q, state_d;
   logic [CAW-1:0]      caddr_q, caddr_d;
   logic                cload_q, cload_d;
   logic [DIV_LOG2-1:0] div_cnt_q, div_cnt_d;
   logic [15:0]         slot_cnt_q, slot_cnt_d;
   logic [SAW-1:0]      saddr_q, saddr_d;
   logic [15:0]         rslots_q, rslots_d;
   logic [OW-1:0]       odata_q, odata_d;
   logic                ovalid_q, ovalid_d;
   logic                done_q, done_d;

   logic                wrap;
   logic                go;
   logic [15:0]         slot_inc;
   logic [SAW-1:0]      saddr_inc;

   assign wrap = (state_q == S_RUN)
              && (div_cnt_q == DMAX);
   assign go   = (state_q == S_IDLE)
              && start && !abort;

   assign slot_inc  = (slot_cnt_q == 16'hFFFF)
                    ? slot_cnt_q
                    : slot_cnt_q + 16'd1;
   assign saddr_inc = (saddr_q == SLAST)
                    ? '0
                    : saddr_q + 1'b1;

   // Next-state and datapath: abort overrides everything, then the FSM.
   // DONE is taken at the wrap that completes the run_slots-th slow period.
   always_comb begin
      state_d    = state_q;
      caddr_d    = caddr_q;
      cload_d    = 1'b0;
      div_cnt_d  = div_cnt_q;
      slot_cnt_d = slot_cnt_q;
      saddr_d    = saddr_q;
      rslots_d   = rslots_q;
      odata_d    = odata_q;
      ovalid_d   = 1'b0;
      done_d     = 1'b0;
      if (abort) begin
         state_d    = S_IDLE;
         caddr_d    = '0;
         div_cnt_d  = '0;
         slot_cnt_d = '0;
         saddr_d    = '0;
      end else begin
         unique case (state_q)
            S_IDLE: begin
               if (start) begin
                  state_d    = S_LOAD;
                  cload_d    = 1'b1;
                  caddr_d    = '0;
                  div_cnt_d  = '0;
                  slot_cnt_d = '0;
                  saddr_d    = '0;
                  rslots_d   = run_slots;
               end
            end
            S_LOAD: begin
               if (caddr_q == CLAST) begin
                  state_d   = S_RUN;
                  caddr_d   = '0;
                  div_cnt_d = '0;
               end else begin
                  cload_d = 1'b1;
                  caddr_d = caddr_q + 1'b1;
               end
            end
            S_RUN: begin
               div_cnt_d = div_cnt_q + 1'b1;
               if (div_cnt_q == CPHASE
                   && slot_cnt_q >= SKIP) begin
                  odata_d  = fir_dout;
                  ovalid_d = 1'b1;
               end
               if (wrap) begin
                  saddr_d    = saddr_inc;
                  slot_cnt_d = slot_inc;
                  if (rslots_q != 16'd0
                      && slot_inc == rslots_q) begin
                     state_d   = S_DONE;
                     div_cnt_d = '0;
                     done_d    = 1'b1;
                  end
               end
            end
            S_DONE: begin
               state_d = S_IDLE;
            end
            default: begin
               state_d = S_IDLE;
            end
         endcase
      end
   end

   // State and datapath registers.
   always_ff @(posedge clk_fast or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         caddr_q    <= '0;
         cload_q    <= 1'b0;
         div_cnt_q  <= '0;
         slot_cnt_q <= '0;
         saddr_q    <= '0;
         rslots_q   <= '0;
         odata_q    <= '0;
         ovalid_q   <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         caddr_q    <= caddr_d;
         cload_q    <= cload_d;
         div_cnt_q  <= div_cnt_d;
         slot_cnt_q <= slot_cnt_d;
         saddr_q    <= saddr_d;
         rslots_q   <= rslots_d;
         odata_q    <= odata_d;
         ovalid_q   <= ovalid_d;
         done_q     <= done_d;
      end
   end

   assign sample_addr  = saddr_q;
   assign fir_caddr    = caddr_q;
   assign fir_cin      = coef_q;
   assign fir_cload    = cload_q;
   assign fir_din      = sample_q;
   assign fir_clk_slow = (state_q == S_RUN)
                       & div_cnt_q[DIV_LOG2-1];
   assign out_data     = odata_q;
   assign out_valid    = ovalid_q;
   assign busy         = (state_q != S_IDLE);
   assign done         = done_q;

`ifdef FIR_SEQ_DENORM_CHECK_EN

   logic denorm_q, denorm_d;

   function automatic logic is_denorm(
      input logic [DW-1:0] v
   );
      return (v[14:10] == 5'd0)
          && (v[9:0] != 10'd0);
   endfunction

   // Sticky flag: cleared by an accepted start, set by a denormal
   // coefficient during load or a denormal sample at a wrap.
   always_comb begin
      denorm_d = denorm_q;
      if (go) begin
         denorm_d = 1'b0;
      end else if ((cload_q && is_denorm(coef_q))
                || (wrap && is_denorm(sample_q))) begin
         denorm_d = 1'b1;
      end
   end

   // Denormal flag register.
   always_ff @(posedge clk_fast or negedge rst_n) begin
      if (!rst_n) begin
         denorm_q <= 1'b0;
      end else begin
         denorm_q <= denorm_d;
      end
   end

   assign denorm_flag = denorm_q;

`else

   logic unused_go;
   assign unused_go   = go;
   assign denorm_flag = 1'b0;

`endif

endmodule

// File: tb/tb_fir_stream_sequencer.sv
// tb_fir_stream_sequencer: directed checks of load, run, capture,
// abort, ignored start and denormal flag on a small configuration.
module tb_fir_stream_sequencer;

   localparam int DW  = 16;
   localparam int OW  = 29;
   localparam int CAW = 2;
   localparam int SAW = 3;

`ifdef FIR_SEQ_DENORM_CHECK_EN
   localparam logic DN_EXP = 1'b1;
`else
   localparam logic DN_EXP = 1'b0;
`endif

   logic            clk_fast;
   logic            rst_n;
   logic            start;
   logic            abort;
   logic [15:0]     run_slots;
   logic [DW-1:0]   coef_q;
   logic [DW-1:0]   sample_q;
   logic [SAW-1:0]  sample_addr;
   logic [CAW-1:0]  fir_caddr;
   logic [DW-1:0]   fir_cin;
   logic            fir_cload;
   logic            fir_clk_slow;
   logic [DW-1:0]   fir_din;
   logic [OW-1:0]   fir_dout;
   logic [OW-1:0]   out_data;
   logic            out_valid;
   logic            busy;
   logic            done;
   logic            denorm_flag;

   logic [DW-1:0] coef_mem [4];
   logic [DW-1:0] sample_mem [5];

   int n_chk;
   int n_pass;
   int nv;

   fir_stream_sequencer #(
      .DW(DW), .OW(OW), .NTAPS(4),
      .SAMPLE_LEN(5), .DIV_LOG2(3),
      .CAPTURE_PHASE(2), .SKIP_SLOTS(1)
   ) dut (
      .clk_fast(clk_fast),
      .rst_n(rst_n),
      .start(start),
      .abort(abort),
      .run_slots(run_slots),
      .coef_q(coef_q),
      .sample_q(sample_q),
      .sample_addr(sample_addr),
      .fir_caddr(fir_caddr),
      .fir_cin(fir_cin),
      .fir_cload(fir_cload),
      .fir_clk_slow(fir_clk_slow),
      .fir_din(fir_din),
      .fir_dout(fir_dout),
      .out_data(out_data),
      .out_valid(out_valid),
      .busy(busy),
      .done(done),
      .denorm_flag(denorm_flag)
   );

   assign coef_q   = coef_mem[fir_caddr];
   assign sample_q = sample_mem[sample_addr];

   initial clk_fast = 1'b0;
   always #5 clk_fast = ~clk_fast;

   task automatic chk(
      input string       tag,
      input logic [31:0] got,
      input logic [31:0] exp
   );
      n_chk++;
      if (got !== exp)
         $display("FAIL %s: got %0h expected %0h",
                  tag, got, exp);
      else
         n_pass++;
   endtask

   task automatic tick();
      @(posedge clk_fast);
      #1;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   initial begin
      n_chk = 0;
      n_pass = 0;
      rst_n = 1'b0;
      start = 1'b0;
      abort = 1'b0;
      run_slots = 16'd0;
      fir_dout = '0;
      for (int i = 0; i < 4; i++)
         coef_mem[i] = 16'h3C00 + 16'(i);
      for (int i = 0; i < 5; i++)
         sample_mem[i] = 16'h4000 + 16'(i);

      #12;
      chk("rst_busy", busy, 0);
      chk("rst_cload", fir_cload, 0);
      chk("rst_caddr", fir_caddr, 0);
      chk("rst_saddr", sample_addr, 0);
      chk("rst_clks", fir_clk_slow, 0);
      chk("rst_valid", out_valid, 0);
      chk("rst_done", done, 0);
      chk("rst_odata", out_data, 0);
      chk("rst_denorm", denorm_flag, 0);
      @(negedge clk_fast);
      rst_n = 1'b1;
      tick();

      // load then 12 slow periods, fir_dout = slot index
      run_slots = 16'd12;
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int c = 0; c < 4; c++) begin
         chk("ld_cload", fir_cload, 1);
         chk("ld_caddr", fir_caddr, c);
         chk("ld_busy", busy, 1);
         chk("ld_cin", fir_cin, 16'h3C00 + 16'(c));
         tick();
      end
      nv = 0;
      for (int k = 0; k < 96; k++) begin
         fir_dout = OW'(k / 8);
         chk("run_cload", fir_cload, 0);
         chk("run_saddr", sample_addr, (k / 8) % 5);
         chk("run_clks", fir_clk_slow, (k % 8) >= 4);
         chk("run_valid", out_valid,
             (k % 8) == 3 && k >= 8);
         if (out_valid) begin
            nv++;
            chk("run_odata", out_data, k / 8);
         end
         chk("run_done", done, 0);
         tick();
      end
      chk("nvalid", nv, 11);
      chk("dn_done", done, 1);
      chk("dn_busy", busy, 1);
      chk("dn_saddr", sample_addr, 2);
      chk("dn_clks", fir_clk_slow, 0);
      tick();
      chk("post_done", done, 0);
      chk("post_busy", busy, 0);
      chk("post_saddr", sample_addr, 2);
      chk("post_odata", out_data, 11);
      chk("post_denorm", denorm_flag, 0);

      // abort during load at caddr 2
      run_slots = 16'd2;
      start = 1'b1;
      tick();
      start = 1'b0;
      ticks(2);
      chk("ab_caddr2", fir_caddr, 2);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      chk("ab_busy", busy, 0);
      chk("ab_cload", fir_cload, 0);
      chk("ab_caddr", fir_caddr, 0);
      chk("ab_done", done, 0);
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("re_cload", fir_cload, 1);
      chk("re_caddr", fir_caddr, 0);
      ticks(4);
      fir_dout = 29'h1ABCDE;
      ticks(5);
      chk("ab_run_clks", fir_clk_slow, 1);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      chk("ab2_busy", busy, 0);
      chk("ab2_clks", fir_clk_slow, 0);
      chk("ab2_valid", out_valid, 0);
      chk("ab2_done", done, 0);
      chk("ab2_odata", out_data, 11);
      tick();
      chk("ab3_done", done, 0);

      // start and abort together; start during run ignored
      start = 1'b1;
      abort = 1'b1;
      tick();
      start = 1'b0;
      abort = 1'b0;
      chk("sa_busy", busy, 0);
      chk("sa_cload", fir_cload, 0);
      run_slots = 16'd3;
      start = 1'b1;
      tick();
      start = 1'b0;
      ticks(4);
      for (int k = 0; k < 24; k++) begin
         start = (k == 10);
         chk("ig_done", done, 0);
         chk("ig_cload", fir_cload, 0);
         tick();
      end
      start = 1'b0;
      chk("ig_done_end", done, 1);
      chk("ig_saddr", sample_addr, 3);
      tick();
      chk("ig_busy", busy, 0);

      // run_slots 0 runs until abort
      run_slots = 16'd0;
      start = 1'b1;
      tick();
      start = 1'b0;
      ticks(4 + 40);
      chk("inf_busy", busy, 1);
      chk("inf_done", done, 0);
      chk("inf_saddr", sample_addr, 0);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      chk("inf_ab_busy", busy, 0);

      // denormal sample at address 3
      sample_mem[3] = 16'h0001;
      run_slots = 16'd5;
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("dn_pre", denorm_flag, 0);
      ticks(4 + 40);
      chk("dn_run_done", done, 1);
      chk("dn_flag", denorm_flag, DN_EXP);
      ticks(3);
      chk("dn_hold", denorm_flag, DN_EXP);
      sample_mem[3] = 16'h4003;
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("dn_clear", denorm_flag, 0);
      abort = 1'b1;
      tick();
      abort = 1'b0;

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
